data_memory_reader: RTL and testbench
=====================================

Name: data_memory_reader

Overview:
Readback engine that drains result words from data memory once all cores have finished processing. It is the reader counterpart of the file-load path that fills data memory before processing. It sequences one read address per cycle into a data memory read port and absorbs the 1-cycle memory latency in a 2-entry output buffer. Words are presented on a valid/ready stream to the result sink (file dumper or UART TX).

Parameters:
ADDR_WIDTH, 8, data memory address width
DATA_WIDTH, 16, data memory word width
NUM_CORES, 4, number of end_process bits that must all be high before reading starts

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
start  input  1  1-cycle request; latches base_addr and word_count
base_addr  input  ADDR_WIDTH  first data memory address to read
word_count  input  ADDR_WIDTH+1  number of words to read (0..256)
end_process  input  NUM_CORES  per-core done flags
mem_addr  output  ADDR_WIDTH  data memory read address
mem_rd_en  output  1  read issued this cycle; data returns on mem_dataout next cycle
mem_dataout  input  DATA_WIDTH  data memory read data, valid 1 cycle after mem_rd_en
out_data  output  DATA_WIDTH  streamed word
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts when out_valid && out_ready
out_last  output  1  high with the final word of the transfer
busy  output  1  high from the accepted start until done
done  output  1  1-cycle pulse after the final word is accepted

Behaviour:
- Reset, asynchronous: state IDLE, all outputs 0, buffer empty, in-flight flag cleared. Reset mid-transfer discards any in-flight read and buffered words. No done pulse is generated.
- States:
  - IDLE: on start, latch base_addr into rd_ptr and word_count into issue_cnt/out_cnt, set busy. If word_count==0, go to FINISH; otherwise go to WAIT_CORES. start is ignored in all states other than IDLE.
  - WAIT_CORES: stay until end_process == all ones, sampled registered. Then go to ISSUE. First mem_rd_en is asserted no earlier than the cycle after all ones is sampled.
  - ISSUE: assert mem_rd_en with mem_addr=rd_ptr when issue_cnt>0 and (buffer occupancy + in-flight) < 2. On each issue, rd_ptr increments modulo 2^ADDR_WIDTH, so 0xFF wraps to 0x00, and issue_cnt decrements. When issue_cnt reaches 0, go to DRAIN.
  - DRAIN: no reads issued. Wait until out_cnt==0.
  - FINISH: pulse done for 1 cycle, clear busy, go to IDLE.
- Data return: the cycle after mem_rd_en, mem_dataout is written into the 2-entry FIFO. Write and read of the FIFO in the same cycle are allowed.
- Output stream:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - out_data is held stable while out_valid && !out_ready.
  - out_last = out_valid && out_cnt==1.
  - out_cnt decrements on each accepted transfer.
- Throughput: with out_ready held high, 1 word per cycle. First out_valid appears 2 cycles after the first mem_rd_en.
- mem_addr holds its last value when mem_rd_en=0.
- busy stays high throughout WAIT_CORES, ISSUE and DRAIN.
- done and start in the same cycle: done completes, the state returns to IDLE, and that start is ignored. A new start is accepted from the next cycle.
- end_process deasserting after reading has begun has no effect.
- word_count=256 with base 0x00 reads every address exactly once.

Test Plan:
- Reset, then start with base=0x10, count=4, end_process=4'b1111, out_ready=1. Memory holds 0x10..0x13 = 0x0001..0x0004 → out_data 0x0001,0x0002,0x0003,0x0004 on consecutive cycles; out_last only on 0x0004; done pulse once; busy falls in the same cycle done is asserted.
- start with end_process=4'b0111 held for 10 cycles, then 4'b1111 → no mem_rd_en during the 10 cycles; reads begin afterwards; data stream is correct.
- base=0xFE, count=4 → mem_addr sequence 0xFE,0xFF,0x00,0x01.
- count=3, out_ready toggled 1,0,0,1,0,1… → no word lost or duplicated; out_data stable while stalled; never more than 2 reads outstanding plus buffered.
- count=0 → done pulses within 2 cycles of start, mem_rd_en never asserted, out_valid never asserted.
- Assert reset during ISSUE of a count=8 transfer → all outputs 0 immediately. A new start with count=2 streams exactly 2 correct words, with no stale data from the aborted transfer.

Source files
------------

// File: rtl/data_memory_reader.sv
// data_memory_reader: once every core has raised end_process, drains a block of
// result words from data memory. Reads go out one address per cycle, and the
// 1-cycle memory latency is absorbed in a 2-entry output buffer.
// Latency: the first out_valid comes 2 cycles after the first mem_rd_en. With
// out_ready held high the stream then runs at 1 word per cycle.
// Backpressure: out_ready low holds out_data. Reads throttle so that buffered
// words plus in-flight words never exceed the 2 buffer slots.
//
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_start                 1-cycle request, accepted only in IDLE
//   i_base_addr             first address to read
//   i_word_count            number of words to read (0..2^ADDR_WIDTH)
//   i_end_process           per-core done flags; all must be high before reading
//   o_mem_addr/o_mem_rd_en  data memory read port (data returns next cycle)
//   i_mem_dataout           data memory read data
//   o_out_data/o_out_valid/i_out_ready/o_out_last   result stream
//   o_busy                  transfer in progress
//   o_done                  1-cycle pulse once the final word has been accepted

module data_memory_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CORES  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    input  logic [NUM_CORES-1:0]  i_end_process,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd_en,
    input  logic [DATA_WIDTH-1:0] i_mem_dataout,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_out_last,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_CORES = 3'd1,
        S_ISSUE      = 3'd2,
        S_DRAIN      = 3'd3,
        S_FINISH     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Transfer bookkeeping
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [ADDR_WIDTH:0]   r_issue_cnt;
    logic [ADDR_WIDTH:0]   r_out_cnt;
    logic                  r_cores_done;
    logic                  r_inflight;

    // 2-entry output buffer
    logic [DATA_WIDTH-1:0] r_fifo_mem [2];
    logic                  r_fifo_wr_idx;
    logic                  r_fifo_rd_idx;
    logic [1:0]            r_fifo_cnt;

    logic                  w_start_acc;
    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_committed;
    logic                  w_issue;

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_push      = r_inflight;
    assign w_pop       = o_out_valid && i_out_ready;

    // Buffer slots still claimed after this edge. A word leaving this cycle
    // frees its slot, which keeps the stream at full rate. The slot count
    // never underflows, because a pop only happens when the buffer is non-empty.
    assign w_committed = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_issue = (r_state == S_ISSUE) && (r_issue_cnt != '0) && (w_committed < 3'd2);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = (i_word_count == '0) ? S_FINISH : S_WAIT_CORES;
                end
            end
            S_WAIT_CORES: begin
                if (r_cores_done) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Leave on the issue that takes the remaining count to zero.
                if ((r_issue_cnt == '0) ||
                    (w_issue && (r_issue_cnt == {{ADDR_WIDTH{1'b0}}, 1'b1}))) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_out_cnt == '0) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_mem_rd_en = w_issue;
        // The address tracks the read pointer only while a read is issued.
        // Otherwise it holds the last address that was sent.
        o_mem_addr  = w_issue ? r_rd_ptr : r_addr_hold;
        unique case (r_state)
            S_WAIT_CORES, S_ISSUE, S_DRAIN: o_busy = 1'b1;
            S_FINISH:                       o_done = 1'b1;
            default:                        ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address / count datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr     <= '0;
            r_addr_hold  <= '0;
            r_issue_cnt  <= '0;
            r_out_cnt    <= '0;
            r_cores_done <= 1'b0;
            r_inflight   <= 1'b0;
        end else begin
            // Registered all-done sample. It decouples the core flags from
            // issue timing. Once reading starts, a later drop has no effect.
            r_cores_done <= &i_end_process;
            r_inflight   <= w_issue;

            if (w_start_acc) begin
                r_rd_ptr    <= i_base_addr;
                r_issue_cnt <= i_word_count;
                r_out_cnt   <= i_word_count;
            end else begin
                if (w_issue) begin
                    r_rd_ptr    <= r_rd_ptr + 1'b1;  // wraps modulo 2^ADDR_WIDTH
                    r_addr_hold <= r_rd_ptr;
                    r_issue_cnt <= r_issue_cnt - 1'b1;
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: write data coming back from memory, read the head
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_fifo_wr_idx <= 1'b0;
            r_fifo_rd_idx <= 1'b0;
            r_fifo_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_fifo_wr_idx] <= i_mem_dataout;
                r_fifo_wr_idx             <= ~r_fifo_wr_idx;
            end
            if (w_pop) begin
                r_fifo_rd_idx <= ~r_fifo_rd_idx;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_out_valid = (r_fifo_cnt != 2'd0);
    assign o_out_data  = r_fifo_mem[r_fifo_rd_idx];
    assign o_out_last  = o_out_valid && (r_out_cnt == {{ADDR_WIDTH{1'b0}}, 1'b1});

endmodule

// File: tb/tb_data_memory_reader.sv
module tb_data_memory_reader;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [NC-1:0] end_process;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_dataout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:255];
    logic [5:0]    ready_pat;

    data_memory_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(NC)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_base_addr  (base_addr),
        .i_word_count (word_count),
        .i_end_process(end_process),
        .o_mem_addr   (mem_addr),
        .o_mem_rd_en  (mem_rd_en),
        .i_mem_dataout(mem_dataout),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_last   (out_last),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory with 1-cycle latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_dataout <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    endtask

    // One complete transfer, scored against the expected address sequence
    // (base+i mod 256) and the expected data (mem at that address).
    // hold:  cycles for which end_process stays incomplete after start
    // rmode: 0 = ready always high, 1 = random ready, 2 = pattern 1,0,0,1,0,1
    task automatic run_xfer(input logic [7:0] base, input logic [8:0] cnt,
                            input int hold, input int rmode, input string tag);
        int            rd_n, acc_n, done_n, first_rd, first_vld, first_acc, last_acc, tail;
        logic [7:0]    addr_q [$];
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [7:0]    exp_addr;
        rd_n = 0; acc_n = 0; done_n = 0; first_rd = -1; first_vld = -1;
        first_acc = -1; last_acc = -1; tail = 0; prev_stall = 1'b0; prev_data = '0;

        @(negedge clk);
        start       = 1'b1;
        base_addr   = base;
        word_count  = cnt;
        end_process = (hold > 0) ? 4'b0111 : 4'b1111;
        out_ready   = 1'b1;

        for (int cyc = 1; cyc <= 4000 && tail < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (hold > 0 && cyc <= hold) end_process = 4'b0111;
            else if (first_rd >= 0)      end_process = 4'($urandom);
            else                         end_process = 4'b1111;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ready_pat[5 - ((cyc - 1) % 6)];
            endcase
            #1;
            if (cyc <= hold + 1) check({tag, "_no_rd_while_waiting"}, mem_rd_en, 1'b0);
            if (mem_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                addr_q.push_back(mem_addr);
                rd_n++;
            end
            if (out_valid) begin
                if (first_vld < 0) begin
                    first_vld = cyc;
                    check({tag, "_first_valid_latency"}, cyc - first_rd, 2);
                end
                if (prev_stall) check({tag, "_stall_hold"}, out_data, prev_data);
                check({tag, "_out_last"}, out_last, (acc_n == int'(cnt) - 1));
                if (out_ready) begin
                    exp_addr = 8'(int'(base) + acc_n);
                    check({tag, "_data"}, out_data, mem[exp_addr]);
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    acc_n++;
                end
            end
            check({tag, "_outstanding_le2"}, (rd_n - acc_n) <= 2, 1'b1);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done_n > 0) begin
                tail++;
                check({tag, "_quiet_after_done"}, {done, out_valid, mem_rd_en}, 3'b000);
            end else if (done) begin
                done_n++;
                check({tag, "_busy_low_at_done"}, busy, 1'b0);
                check({tag, "_all_accepted_at_done"}, acc_n, cnt);
            end else begin
                check({tag, "_busy_high"}, busy, 1'b1);
            end
        end

        check({tag, "_done_pulses"}, done_n, 1);
        check({tag, "_reads_issued"}, rd_n, cnt);
        check({tag, "_words_accepted"}, acc_n, cnt);
        for (int i = 0; i < addr_q.size(); i++) begin
            exp_addr = 8'(int'(base) + i);
            check({tag, "_addr_seq"}, addr_q[i], exp_addr);
        end
        if (rmode == 0) check({tag, "_back_to_back"}, last_acc - first_acc, int'(cnt) - 1);
    endtask

    initial begin
        int seen_done;
        ready_pat   = 6'b100101;
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        word_count  = '0;
        end_process = '0;
        out_ready   = 1'b0;
        fill_mem();

        // Reset state
        #12;
        check("rst_outputs", {mem_addr, mem_rd_en, out_data, out_valid, out_last, busy, done}, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_outputs", {mem_rd_en, out_valid, out_last, busy, done}, 5'b0);

        // Basic transfer with known contents
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 16'(i + 1);
        run_xfer(8'h10, 9'd4, 0, 0, "basic");

        // Cores finish late
        fill_mem();
        run_xfer(8'($urandom), 9'd6, 10, 0, "wait_cores");

        // Address wrap
        run_xfer(8'hFE, 9'd4, 0, 0, "wrap");

        // Toggled ready
        run_xfer(8'($urandom), 9'd3, 0, 2, "stall");

        // Random transfers
        for (int t = 0; t < 3; t++) begin
            fill_mem();
            run_xfer(8'($urandom), 9'($urandom_range(1, 40)), $urandom_range(0, 5), 1, "rand");
        end

        // Full address space
        run_xfer(8'h00, 9'd256, 0, 1, "full");

        // Zero-length transfer
        @(negedge clk);
        start = 1'b1; base_addr = 8'h33; word_count = 9'd0; end_process = 4'b1111; out_ready = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 2 && seen_done == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check("zero_no_rd", mem_rd_en, 1'b0);
            check("zero_no_valid", out_valid, 1'b0);
            if (done) seen_done = 1;
        end
        check("zero_done_within_2", seen_done, 1);

        // Start arriving in the same cycle as done is ignored
        @(negedge clk);
        start = 1'b1; word_count = 9'd0;
        @(negedge clk);
        start = 1'b1; word_count = 9'd5; base_addr = 8'h40;
        #1;
        check("coincide_done", done, 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("coincide_ignored", {busy, mem_rd_en, done}, 3'b000);
            @(negedge clk);
        end

        // Reset in the middle of an 8-word transfer
        fill_mem();
        start = 1'b1; base_addr = 8'($urandom); word_count = 9'd8; end_process = 4'b1111; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        for (int k = 0; k < 20 && !mem_rd_en; k++) begin
            @(negedge clk);
            #1;
        end
        check("abort_reached_issue", mem_rd_en, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_outputs_zero", {mem_addr, mem_rd_en, out_data, out_valid, out_last, busy, done}, '0);
        @(negedge clk);
        reset = 1'b0;
        fill_mem();
        run_xfer(8'($urandom), 9'd2, 0, 1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
